// File: rtl/neuron_act_stage_if.sv
// rtl/neuron_act_stage_if.sv - handshake bundle between accumulator, activation stage and next layer
//
// Purpose: groups the accumulator-side and consumer-side handshake signals of
// neuron_act_stage so the stage exposes a single bus port.
//
// Signals:
//   acc_in    [IN_W]    signed neuron sum from the accumulator register
//   acc_valid           acc_in holds a completed sum
//   acc_ready           stage can accept a sum this cycle
//   act_out   [OUT_W]   activation at the FIFO head
//   act_sat             head entry was clipped at the positive limit
//   act_valid           FIFO is non-empty
//   act_ready           consumer pops the head this cycle
//   count     [CNT_W]   FIFO occupancy
//
// Modports:
//   slave  - the activation stage (consumes sums, produces activations)
//   master - the environment (accumulator driver plus next-layer consumer)

interface neuron_act_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  acc_in;
  logic             acc_valid;
  logic             acc_ready;
  logic [OUT_W-1:0] act_out;
  logic             act_sat;
  logic             act_valid;
  logic             act_ready;
  logic [CNT_W-1:0] count;

  modport slave (
    input  acc_in,
    input  acc_valid,
    output acc_ready,
    output act_out,
    output act_sat,
    output act_valid,
    input  act_ready,
    output count
  );

  modport master (
    output acc_in,
    output acc_valid,
    input  acc_ready,
    input  act_out,
    input  act_sat,
    input  act_valid,
    output act_ready,
    input  count
  );

endinterface

// File: rtl/neuron_act_stage.sv
// rtl/neuron_act_stage.sv - ReLU, arithmetic-shift rescale and 8-bit saturation with output FIFO
//
// Purpose: captures a completed signed neuron sum, converts it to a
// non-negative OUT_W-bit activation (ReLU, >>> SHIFT, clip at 2^(OUT_W-1)-1)
// and buffers {sat, activation} in a DEPTH-entry FIFO for the next layer.
// Flow control is credit based: acc_ready is derived only from registered
// state, never from act_ready.
//
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous, active-high reset
//   io_bus  neuron_act_stage_if.slave
//             acc_in/acc_valid/acc_ready   sum input handshake
//             act_out/act_sat/act_valid/act_ready  activation output handshake
//             count                        FIFO occupancy, 0 .. DEPTH

module neuron_act_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  neuron_act_stage_if.slave     io_bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Largest representable activation, in both the sum domain (for the
  // compare) and the output domain (for the clipped value).
  localparam logic [IN_W-1:0]  LIMIT_T = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'((1 << (OUT_W - 1)) - 1);

  // Stage register S1
  logic [IN_W-1:0]  r_s1;
  logic             r_s1_v;

  // FIFO storage and bookkeeping
  logic [OUT_W-1:0] r_mem_data [0:DEPTH-1];
  logic             r_mem_sat  [0:DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [IN_W-1:0]  w_shifted;
  logic [OUT_W-1:0] w_result;
  logic             w_sat;
  logic [CNT_W:0]   w_credit_sum;

  // Credits: everything accepted and not yet popped is either in S1 or in
  // the FIFO, so count + s1_v bounds the space that could still be needed.
  // A pop in the same cycle is deliberately ignored to keep acc_ready free
  // of any combinational path from act_ready.
  assign w_credit_sum     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_v};
  assign io_bus.acc_ready = (w_credit_sum < (CNT_W + 1)'(DEPTH));

  assign w_accept = io_bus.acc_valid && io_bus.acc_ready;
  assign w_push   = r_s1_v;
  assign w_pop    = (r_count != '0) && io_bus.act_ready;

  // Activation compute on S1
  assign w_shifted = IN_W'($signed(r_s1) >>> SHIFT);

  always_comb begin
    w_result = '0;
    w_sat    = 1'b0;
    if (r_s1[IN_W-1]) begin
      // ReLU: any negative sum maps to zero, never flagged.
      w_result = '0;
      w_sat    = 1'b0;
    end else if (w_shifted > LIMIT_T) begin
      w_result = OUT_MAX;
      w_sat    = 1'b1;
    end else begin
      // Exactly LIMIT_T passes through unflagged.
      w_result = w_shifted[OUT_W-1:0];
      w_sat    = 1'b0;
    end
  end

  // S1 capture: valid for exactly the cycle after an accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s1_v <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1 <= io_bus.acc_in;
      end
    end
  end

  // FIFO storage. The write is unconditional on s1_v because credits have
  // already reserved the slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_sat[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_result;
      r_mem_sat[r_wr_ptr]  <= w_sat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count is kept
  // explicitly so full (count == DEPTH) and empty are distinguishable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registered storage at the head.
  assign io_bus.act_out   = r_mem_data[r_rd_ptr];
  assign io_bus.act_sat   = r_mem_sat[r_rd_ptr];
  assign io_bus.act_valid = (r_count != '0);
  assign io_bus.count     = r_count;

endmodule
